alu_seq: RTL

Sequential, parametrised integer ALU for the core's execute stage. It keeps the existing 4-bit opcode map for shift, add/sub, logic and compare operations and adds:
- a signed compare,
- an iterative unsigned multiplier,
- an optional iterative unsigned divider.

A valid/ready handshake on each side lets the issue logic stall on multi-cycle operations.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_muldiv.sv | 114 +++++++++++
 rtl/alu_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types and constants for the sequential execute-stage ALU.
//            Holds the opcode map, FSM state encoding and the results
//            returned for an unsigned divide by zero.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode map. The encodings are fixed by the issue logic.
  typedef enum logic [3:0] {
    OP_SLL   = 4'b0000,
    OP_SRL   = 4'b0001,
    OP_SRA   = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_AND   = 4'b0101,
    OP_OR    = 4'b0110,
    OP_XOR   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_EQ    = 4'b1001,
    OP_NE    = 4'b1010,
    OP_SLT   = 4'b1011,
    OP_MUL   = 4'b1100,
    OP_MULHU = 4'b1101,
    OP_DIVU  = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  // Top-level control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Divide by zero: every quotient bit is this value (all ones).
  localparam logic DIV0_QUO_FILL = 1'b1;
  // Divide by zero: the remainder is the unmodified dividend.
  localparam logic DIV0_REM_KEEPS_OP1 = 1'b1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Iterative unsigned multiply / divide engine, one bit per cycle.
//            Operands load on start; after WIDTH steps the result is held
//            until the next start. 'last' flags the final step.
//            The restoring divider is built only when ALU_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  alu_op_e          r_op;
  // Multiply: {r_hi, r_lo} is the partial product with the multiplier
  // shifting out of r_lo. Divide: r_hi is the partial remainder and r_lo
  // shifts dividend bits out while quotient bits shift in.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH-1:0] w_next;
`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
`endif

  assign last = r_busy && (r_cnt == CW'(WIDTH - 1));

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_next = {w_sum, r_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_op == OP_DIVU || r_op == OP_REMU) begin
      // A non-negative trial difference means the divisor fits: keep it.
      if (!w_diff[WIDTH]) begin
        w_next = {w_diff[WIDTH-1:0], r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_next = {w_shift[WIDTH-1:0], r_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Operand load on start, then WIDTH iterations; rst aborts at any point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_op   <= OP_MUL;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
`ifdef ALU_DIV_EN
      r_a    <= '0;
`endif
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_op   <= op;
      r_hi   <= '0;
      r_lo   <= a;
      r_b    <= b;
`ifdef ALU_DIV_EN
      r_a    <= a;
`endif
    end else if (r_busy) begin
      // Counter wraps back to zero on the final step.
      r_cnt        <= r_cnt + CW'(1);
      {r_hi, r_lo} <= w_next;
      if (last) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Select the requested half / quotient / remainder.
  always_comb begin
    result = r_lo;
    case (r_op)
      OP_MULHU: result = r_hi;
`ifdef ALU_DIV_EN
      OP_DIVU: begin
        if (r_b == '0) result = {WIDTH{DIV0_QUO_FILL}};
      end
      OP_REMU: begin
        result = (r_b == '0 && DIV0_REM_KEEPS_OP1) ? r_a : r_hi;
      end
`endif
      default: ;
    endcase
  end

endmodule : alu_muldiv
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Sequential integer ALU with valid/ready handshakes. Single-cycle
//            ops complete in one cycle; MUL/MULHU (and DIVU/REMU when the
//            ALU_DIV_EN macro is defined) use the iterative alu_muldiv engine.
//            Without ALU_DIV_EN, DIVU/REMU return 0 with alu_err set.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_err
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_e          w_op;
  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic             w_accept;
  logic             w_multi;
  logic [WIDTH-1:0] w_single;
  logic             w_single_err;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic             r_use_eng;
  logic             w_eng_last;
  logic [WIDTH-1:0] w_eng_result;

  assign w_op = alu_op_e'(ALUOp);

  // Single-cycle datapath and classification of iterative opcodes.
  always_comb begin
    w_single     = '0;
    w_single_err = 1'b0;
    w_multi      = 1'b0;
    case (w_op)
      OP_SLL:  w_single = op1 << op2[SHW-1:0];
      OP_SRL:  w_single = op1 >> op2[SHW-1:0];
      OP_SRA:  w_single = $unsigned($signed(op1) >>> op2[SHW-1:0]);
      OP_ADD:  w_single = op1 + op2;
      OP_SUB:  w_single = op1 - op2;
      OP_AND:  w_single = op1 & op2;
      OP_OR:   w_single = op1 | op2;
      OP_XOR:  w_single = op1 ^ op2;
      OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_EQ:   w_single = {{(WIDTH-1){1'b0}}, (op1 == op2)};
      OP_NE:   w_single = {{(WIDTH-1){1'b0}}, (op1 != op2)};
      OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_MUL, OP_MULHU: w_multi = 1'b1;
      OP_DIVU, OP_REMU: begin
`ifdef ALU_DIV_EN
        w_multi = 1'b1;
`else
        w_single_err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_multi ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (w_eng_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus result capture at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_use_eng <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_use_eng <= w_multi;
        r_result  <= w_single;
        r_err     <= w_single_err;
      end
    end
  end

  // Engine result is read in place; it holds until the next start.
  assign alu_result = r_use_eng ? w_eng_result : r_result;
  assign alu_err    = r_err;

  alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_accept & w_multi),
    .op     (w_op),
    .a      (op1),
    .b      (op2),
    .last   (w_eng_last),
    .result (w_eng_result)
  );

endmodule : alu_seq
`default_nettype wire
